// File: rtl/reverb_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reverb_ctrl_pkg : shared widths, state encoding, delay clamp       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package reverb_ctrl_pkg;

  localparam int unsigned DELAY_W = 10;
  localparam int unsigned GAIN_W  = 8;
  localparam int unsigned SHIFT_W = 3;
  localparam logic [GAIN_W-1:0] GAIN_MAX = 8'd255;

  typedef enum logic [2:0] {
    ST_FADE_OUT = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_FILL     = 3'd2,
    ST_FADE_IN  = 3'd3,
    ST_RUN      = 3'd4
  } state_e;

  function automatic logic [DELAY_W-1:0] clamp_delay(
    input logic [DELAY_W-1:0] req,
    input logic [DELAY_W-1:0] min_d
  );
    return (req < min_d) ? min_d : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gain_ramp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gain_ramp : saturating up/down wet-gain ramp with synchronous clear|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gain_ramp
  import reverb_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              up_i,
  input  logic              down_i,
  input  logic [GAIN_W-1:0] step_i,
  output logic [GAIN_W-1:0] gain_o,
  output logic [GAIN_W-1:0] gain_nxt_o
);

  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [GAIN_W:0]   sum, diff;

  // One extra bit carries overflow on the way up and the borrow on the way down.
  always_comb begin
    sum    = {1'b0, gain_q} + {1'b0, step_i};
    diff   = {1'b0, gain_q} - {1'b0, step_i};
    gain_d = gain_q;
    if (clear_i)
      gain_d = '0;
    else if (up_i)
      gain_d = sum[GAIN_W] ? GAIN_MAX : sum[GAIN_W-1:0];
    else if (down_i)
      gain_d = diff[GAIN_W] ? '0 : diff[GAIN_W-1:0];
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) gain_q <= '0;
    else        gain_q <= gain_d;
  end

  assign gain_o     = gain_q;
  assign gain_nxt_o = gain_d;

endmodule
`default_nettype wire

// File: rtl/reverb_delay_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reverb_delay_ctrl : delay-line config owner with click-free reconfig|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module reverb_delay_ctrl
  import reverb_ctrl_pkg::*;
#(
  parameter int unsigned DEFAULT_DELAY = 512,
  parameter int unsigned MIN_DELAY     = 4,
  parameter int unsigned GAIN_STEP     = 8,
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned DEFAULT_SHIFT = 1
) (
  input  logic               Clk,
  input  logic               rst_n,
  input  logic               sample_stb_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [DELAY_W-1:0] cfg_delay_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  output logic [DELAY_W-1:0] delay_num_o,
  output logic [SHIFT_W-1:0] fb_shift_o,
  output logic               line_flush_o,
  output logic               line_wr_en_o,
  output logic [GAIN_W-1:0]  wet_gain_o,
  output logic               busy_o
);

  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [DELAY_W-1:0] DEF_DELAY  = DELAY_W'(DEFAULT_DELAY);
  localparam logic [DELAY_W-1:0] MIN_DLY    = DELAY_W'(MIN_DELAY);
  localparam logic [SHIFT_W-1:0] DEF_SHIFT  = SHIFT_W'(DEFAULT_SHIFT);
  localparam logic [GAIN_W-1:0]  STEP       = GAIN_W'(GAIN_STEP);

  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   delay_num_q, delay_num_d;
  logic [SHIFT_W-1:0]   fb_shift_q, fb_shift_d;
  logic [DELAY_W-1:0]   pend_delay_q, pend_delay_d;
  logic [SHIFT_W-1:0]   pend_shift_q, pend_shift_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DELAY_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic                 line_flush_q, line_flush_d;
  logic                 line_wr_en_q, line_wr_en_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 busy_q, busy_d;
  logic                 ramp_up, ramp_down, ramp_clear;
  logic [GAIN_W-1:0]    gain, gain_nxt;
  logic [DELAY_W-1:0]   req_delay;
  logic                 cfg_fire;

  assign cfg_fire  = cfg_valid_i & cfg_ready_q;
  assign req_delay = clamp_delay(cfg_delay_i, MIN_DLY);

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FLUSH;
      delay_num_q  <= DEF_DELAY;
      fb_shift_q   <= DEF_SHIFT;
      pend_delay_q <= DEF_DELAY;
      pend_shift_q <= DEF_SHIFT;
      flush_cnt_q  <= '0;
      fill_cnt_q   <= '0;
      line_flush_q <= 1'b1;
      line_wr_en_q <= 1'b0;
      cfg_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      delay_num_q  <= delay_num_d;
      fb_shift_q   <= fb_shift_d;
      pend_delay_q <= pend_delay_d;
      pend_shift_q <= pend_shift_d;
      flush_cnt_q  <= flush_cnt_d;
      fill_cnt_q   <= fill_cnt_d;
      line_flush_q <= line_flush_d;
      line_wr_en_q <= line_wr_en_d;
      cfg_ready_q  <= cfg_ready_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    delay_num_d  = delay_num_q;
    fb_shift_d   = fb_shift_q;
    pend_delay_d = pend_delay_q;
    pend_shift_d = pend_shift_q;
    flush_cnt_d  = flush_cnt_q;
    fill_cnt_d   = fill_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        // A request for the current length only retunes feedback; no reconfig needed.
        if (cfg_fire) begin
          if (req_delay == delay_num_q) begin
            fb_shift_d = cfg_shift_i;
          end else begin
            pend_delay_d = req_delay;
            pend_shift_d = cfg_shift_i;
            state_d      = ST_FADE_OUT;
          end
        end
      end
      ST_FADE_OUT: begin
        if (sample_stb_i && (gain_nxt == '0)) begin
          state_d     = ST_FLUSH;
          delay_num_d = pend_delay_q;
          fb_shift_d  = pend_shift_q;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
      end
      ST_FILL: begin
        if (sample_stb_i) begin
          if (fill_cnt_q == (delay_num_q - DELAY_W'(1))) state_d = ST_FADE_IN;
          else fill_cnt_d = fill_cnt_q + DELAY_W'(1);
        end
      end
      ST_FADE_IN: begin
        if (sample_stb_i && (gain_nxt == GAIN_MAX)) state_d = ST_RUN;
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_comb begin
    line_flush_d = (state_d == ST_FLUSH);
    busy_d       = (state_d != ST_RUN);
    cfg_ready_d  = (state_d == ST_RUN);
    line_wr_en_d = sample_stb_i && (state_q != ST_FLUSH);
    ramp_up      = sample_stb_i && (state_q == ST_FADE_IN);
    ramp_down    = sample_stb_i && (state_q == ST_FADE_OUT);
    ramp_clear   = (state_q == ST_FLUSH) || (state_q == ST_FILL);
  end

  gain_ramp u_gain_ramp (
    .Clk        (Clk),
    .rst_n      (rst_n),
    .clear_i    (ramp_clear),
    .up_i       (ramp_up),
    .down_i     (ramp_down),
    .step_i     (STEP),
    .gain_o     (gain),
    .gain_nxt_o (gain_nxt)
  );

  assign cfg_ready_o  = cfg_ready_q;
  assign delay_num_o  = delay_num_q;
  assign fb_shift_o   = fb_shift_q;
  assign line_flush_o = line_flush_q;
  assign line_wr_en_o = line_wr_en_q;
  assign wet_gain_o   = gain;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reverb_delay_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reverb_delay_ctrl : random-strobe scoreboard bench               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_reverb_delay_ctrl;

  logic       Clk = 1'b0;
  logic       rst_n;
  logic       sample_stb;
  logic       cfg_valid;
  logic [9:0] cfg_delay;
  logic [2:0] cfg_shift;
  logic       cfg_ready;
  logic [9:0] delay_num;
  logic [2:0] fb_shift;
  logic       line_flush;
  logic       line_wr_en;
  logic [7:0] wet_gain;
  logic       busy;

  always #5 Clk = ~Clk;

  reverb_delay_ctrl dut (
    .Clk          (Clk),
    .rst_n        (rst_n),
    .sample_stb_i (sample_stb),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_delay_i  (cfg_delay),
    .cfg_shift_i  (cfg_shift),
    .delay_num_o  (delay_num),
    .fb_shift_o   (fb_shift),
    .line_flush_o (line_flush),
    .line_wr_en_o (line_wr_en),
    .wet_gain_o   (wet_gain),
    .busy_o       (busy)
  );

  typedef struct packed {
    logic [9:0] dn;
    logic [2:0] fs;
    logic       lf;
    logic       we;
    logic [7:0] g;
    logic       b;
    logic       r;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: a named phase plus plain integer bookkeeping.
  string m_phase;
  int    m_gain, m_dly, m_shift, m_pend_d, m_pend_s, m_flush_left, m_filled;
  bit    m_wr, m_took;
  int    stb_gap;

  function automatic void model_reset();
    m_phase      = "FLUSH";
    m_gain       = 0;
    m_dly        = 512;
    m_shift      = 1;
    m_pend_d     = 512;
    m_pend_s     = 1;
    m_flush_left = 4;
    m_filled     = 0;
    m_wr         = 0;
    m_took       = 0;
  endfunction

  function automatic void model_clock(bit stb, bit v, int cd, int cs);
    int d;
    m_took = 0;
    m_wr   = stb && (m_phase != "FLUSH");
    if (m_phase == "RUN") begin
      if (v) begin
        m_took = 1;
        d = (cd < 4) ? 4 : cd;
        if (d == m_dly) m_shift = cs;
        else begin
          m_pend_d = d;
          m_pend_s = cs;
          m_phase  = "FADE_OUT";
        end
      end
    end else if (m_phase == "FADE_OUT") begin
      if (stb) begin
        m_gain = (m_gain > 8) ? m_gain - 8 : 0;
        if (m_gain == 0) begin
          m_phase      = "FLUSH";
          m_dly        = m_pend_d;
          m_shift      = m_pend_s;
          m_flush_left = 4;
        end
      end
    end else if (m_phase == "FLUSH") begin
      m_flush_left = m_flush_left - 1;
      if (m_flush_left == 0) begin
        m_phase  = "FILL";
        m_filled = 0;
      end
    end else if (m_phase == "FILL") begin
      if (stb) begin
        m_filled = m_filled + 1;
        if (m_filled == m_dly) m_phase = "FADE_IN";
      end
    end else if (m_phase == "FADE_IN") begin
      if (stb) begin
        m_gain = (m_gain + 8 > 255) ? 255 : m_gain + 8;
        if (m_gain == 255) m_phase = "RUN";
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.dn = 10'(m_dly);
    o.fs = 3'(m_shift);
    o.lf = (m_phase == "FLUSH");
    o.we = m_wr;
    o.g  = 8'(m_gain);
    o.b  = (m_phase != "RUN");
    o.r  = (m_phase == "RUN");
    return o;
  endfunction

  task automatic clk_step();
    @(posedge Clk);
    #1;
    if (!rst_n) model_reset();
    else        model_clock(sample_stb, cfg_valid, int'(cfg_delay), int'(cfg_shift));
  endtask

  task automatic drive(input bit v, input int d, input int s, input bit rn);
    bit stb;
    if (stb_gap == 0) begin
      stb     = 1'b1;
      stb_gap = $urandom_range(2, 5);
    end else begin
      stb     = 1'b0;
      stb_gap = stb_gap - 1;
    end
    rst_n      = rn;
    sample_stb = stb;
    cfg_valid  = v;
    cfg_delay  = 10'(d);
    cfg_shift  = 3'(s);
    if (!rn) model_reset();
    exp_q.push_back(model_obs());
  endtask

  task automatic idle_until(input string ph, input int budget);
    int i;
    for (i = 0; i < budget && m_phase != ph; i++) begin
      clk_step();
      drive(0, 0, 0, 1);
    end
    if (m_phase != ph) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: still in %s after %0d cycles, required %s", ph, m_phase, budget, ph);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clk_step();
      drive(0, 0, 0, 1);
    end
  endtask

  task automatic cfg(input int d, input int s, input int budget);
    bit took = 0;
    for (int i = 0; i < budget && !took; i++) begin
      clk_step();
      took = m_took;
      drive(!took, d, s, 1);
    end
    if (!took) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_accept: request delay=%0d not taken in %0d cycles, required acceptance", d, budget);
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {delay_num, fb_shift, line_flush, line_wr_en, wet_gain, busy, cfg_ready};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got dn=%0d fs=%0d flush=%b wr=%b gain=%0d busy=%b rdy=%b, required dn=%0d fs=%0d flush=%b wr=%b gain=%0d busy=%b rdy=%b",
                   $time, a.dn, a.fs, a.lf, a.we, a.g, a.b, a.r, e.dn, e.fs, e.lf, e.we, e.g, e.b, e.r);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n      = 1'b0;
    sample_stb = 1'b0;
    cfg_valid  = 1'b0;
    cfg_delay  = '0;
    cfg_shift  = '0;
    stb_gap    = 3;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      clk_step();
      drive(0, 0, 0, 0);
    end
    clk_step();
    drive(0, 0, 0, 1);
    idle_until("RUN", 6000);
    idle(10);

    cfg(100, 2, 10);
    idle_until("RUN", 3000);
    cfg(100, 3, 10);
    idle(20);

    cfg(0, 5, 10);
    idle_until("RUN", 2000);

    cfg(50, 4, 10);
    idle_until("FADE_IN", 3000);
    cfg(200, 6, 1000);
    idle_until("RUN", 4000);

    cfg(30, 1, 10);
    idle_until("FILL", 2000);
    idle(12);
    clk_step();
    drive(0, 0, 0, 0);
    clk_step();
    drive(0, 0, 0, 0);
    clk_step();
    drive(0, 0, 0, 1);
    idle_until("RUN", 6000);

    for (int k = 0; k < 4; k++) begin
      cfg($urandom_range(0, 150), $urandom_range(0, 7), 10);
      idle_until("RUN", 3000);
      idle($urandom_range(1, 20));
    end

    @(negedge Clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
